vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have port clk  input  1  pixel clock, single clock domain.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port fetch_req  input  1  one-cycle pulse from the VGA timing block at the start of horizontal blanking.
REQ-004 SHALL have port fetch_line  input  9  index (0-479) of the line to prefetch; sampled with fetch_req.
REQ-005 SHALL have port fetch_done  output  1  one-cycle pulse when the whole line is in the line buffer.
REQ-006 SHALL have port fetch_err  output  1  sticky flag for overrun or out-of-range line.
REQ-007 SHALL have port host_wr_valid  input  1  host write request.
REQ-008 SHALL have port host_wr_ready  output  1  host write accepted when high with valid.
REQ-009 SHALL have port host_wr_addr  input  14  frame-buffer word address, 0-9599.
REQ-010 SHALL have port host_wr_data  input  32  32 mono pixels, bit 0 leftmost.
REQ-011 SHALL have ports mem_en, mem_we (output 1), mem_addr (output 14), mem_wdata (output 32), mem_rdata (input 32) for the single-port frame buffer with 1-cycle read latency.
REQ-012 SHALL have ports lb_wr_en (output 1), lb_wr_idx (output 5), lb_wr_data (output 32) to the line buffer.

Function
REQ-013 SHALL implement states IDLE, FETCH and HOST.
REQ-014 In IDLE, fetch_req with fetch_line<480 SHALL move to FETCH, latching base = fetch_line*20 (14-bit, no overflow).
REQ-015 In FETCH, SHALL issue 20 back-to-back reads: cycles 1..20 after fetch_req, mem_en=1, mem_we=0, mem_addr=base+0..base+19.
REQ-016 Each read word SHALL be written to the line buffer one cycle later: lb_wr_en=1, lb_wr_idx=0..19, lb_wr_data=mem_rdata, on cycles 2..21.
REQ-017 fetch_done SHALL pulse on cycle 21, with the final lb write; the state SHALL then return to IDLE.
REQ-018 host_wr_ready SHALL equal (state==IDLE && !fetch_req); fetch always wins in a same-cycle conflict.
REQ-019 An accepted host write SHALL enter HOST for exactly one cycle: mem_en=1, mem_we=1, with the captured address and data; the state SHALL then return to IDLE. Maximum host throughput is 1 write per 2 cycles.
REQ-020 fetch_req arriving in HOST SHALL be held pending and start FETCH on the next cycle; total latency then +1 cycle.
REQ-021 fetch_req arriving in FETCH SHALL be ignored and set fetch_err.
REQ-022 fetch_line>=480 SHALL be ignored and set fetch_err.
REQ-023 host_wr_addr>=9600 SHALL be accepted, discarded (no mem_en) and set fetch_err.
REQ-024 fetch_err SHALL clear only on reset.
REQ-025 mem_en, mem_we, lb_wr_en and fetch_done SHALL be 0 whenever not specified above.

Reset
REQ-026 On reset, the state SHALL be IDLE, all outputs 0, the pending fetch cleared and fetch_err cleared; host_wr_ready SHALL go to 1 on the first cycle after deassertion.
REQ-027 Reset asserted during FETCH or HOST SHALL abort the operation immediately; no partial line completion is signalled.

Configuration
REQ-028 With VGA_ARB_STATS_EN defined, SHALL add output stall_cnt (16), counting cycles with host_wr_valid=1 and host_wr_ready=0, saturating at 0xFFFF and reset to 0.
REQ-029 Without VGA_ARB_STATS_EN, the stall_cnt port and its counter SHALL NOT exist.

Structure
REQ-030 Package vga_pkg SHALL hold H_ACTIVE=640, V_ACTIVE=480, WORDS_PER_LINE=20, FB_WORDS=9600, the address/index widths and the state enum.
REQ-031 Sub-module vga_line_fetch SHALL hold the base/word-index counter and the 1-cycle read-to-line-buffer pipeline register.

Verification
REQ-032 fetch_req with fetch_line=5 -> mem_addr 100..119 on cycles 1..20, lb_wr_idx 0..19 on cycles 2..21, fetch_done on cycle 21.
REQ-033 host write addr=42, data=0xDEADBEEF with the arbiter idle -> accepted same cycle, mem_we=1 with addr 42 the next cycle; ready low for that cycle.
REQ-034 fetch_req and host_wr_valid in the same IDLE cycle -> ready=0, fetch proceeds, host accepted in the cycle after fetch_done.
REQ-035 fetch_req during FETCH, and separately fetch_line=480 -> request ignored, fetch_err=1 and held until reset.
REQ-036 rst_n low at cycle 10 of a fetch -> all outputs 0 immediately, no fetch_done, ready=1 after release.
REQ-037 (VGA_ARB_STATS_EN) host valid held through a full fetch -> stall_cnt=21.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, widths and arbiter state type for the VGA frame-buffer arbiter.
package vga_pkg;

  localparam int unsigned H_ACTIVE       = 640;
  localparam int unsigned V_ACTIVE       = 480;
  localparam int unsigned WORDS_PER_LINE = 20;
  localparam int unsigned FB_WORDS       = 9600;

  localparam int unsigned LINE_W = 9;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] FB_LAST   = ADDR_W'(FB_WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_WORD = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [IDX_W-1:0]  WORD_END  = IDX_W'(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOST  = 2'd2
  } arb_state_e;

  // line * 20 as line*16 + line*4; the largest valid line (479) gives 9580.
  function automatic logic [ADDR_W-1:0] line_base(input logic [LINE_W-1:0] line);
    return ADDR_W'({line, 4'b0000}) + ADDR_W'({line, 2'b00});
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Line-buffer write port driven by the line-fetch engine towards the VGA line buffer.
interface vga_fb_arbiter_if;
  import vga_pkg::*;

  logic              lb_wr_en;
  logic [IDX_W-1:0]  lb_wr_idx;
  logic [DATA_W-1:0] lb_wr_data;

  modport master (output lb_wr_en, lb_wr_idx, lb_wr_data);
  modport slave  (input  lb_wr_en, lb_wr_idx, lb_wr_data);

endinterface

// File: rtl/vga_line_fetch.sv
// Line fetch engine: word counter over one line and the read-to-line-buffer pipeline stage.
module vga_line_fetch
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic              active,
  input  logic [DATA_W-1:0] rdata,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              done,
  vga_fb_arbiter_if.master  lb
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;

  always_comb begin
    base_d   = base_q;
    cnt_d    = cnt_q;
    rd_en    = active && (cnt_q != WORD_END);
    rd_addr  = rd_en ? (base_q + ADDR_W'(cnt_q)) : '0;
    wr_en_d  = rd_en;
    wr_idx_d = rd_en ? cnt_q : '0;
    if (start) begin
      base_d = base;
      cnt_d  = '0;
    end else if (rd_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      cnt_q    <= '0;
      wr_en_q  <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      wr_en_q  <= wr_en_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  // Read data arrives one cycle after the address, aligned with the registered enable.
  assign lb.lb_wr_en   = wr_en_q;
  assign lb.lb_wr_idx  = wr_idx_q;
  assign lb.lb_wr_data = wr_en_q ? rdata : '0;
  assign done          = wr_en_q && (wr_idx_q == LAST_WORD);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: line prefetch for VGA scan-out has priority over host writes.
// Optional stall_cnt statistics output is built when VGA_ARB_STATS_EN is defined.
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_req,
  input  logic [LINE_W-1:0]   fetch_line,
  output logic                fetch_done,
  output logic                fetch_err,
  input  logic                host_wr_valid,
  output logic                host_wr_ready,
  input  logic [ADDR_W-1:0]   host_wr_addr,
  input  logic [DATA_W-1:0]   host_wr_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                lb_wr_en,
  output logic [IDX_W-1:0]    lb_wr_idx,
  output logic [DATA_W-1:0]   lb_wr_data
`ifdef VGA_ARB_STATS_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  arb_state_e        state_q, state_d;
  logic              alive_q;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_base_q, pend_base_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] host_addr_q, host_addr_d;
  logic [DATA_W-1:0] host_data_q, host_data_d;
  logic              host_ok_q, host_ok_d;

  logic              fetch_start;
  logic [ADDR_W-1:0] fetch_base;
  logic              line_ok;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              done;

  vga_fb_arbiter_if lb_bus ();

  vga_line_fetch u_line_fetch (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (fetch_start),
    .base    (fetch_base),
    .active  (state_q == ST_FETCH),
    .rdata   (mem_rdata),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .done    (done),
    .lb      (lb_bus.master)
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_base_d = pend_base_q;
    err_d       = err_q;
    host_addr_d = host_addr_q;
    host_data_d = host_data_q;
    host_ok_d   = host_ok_q;
    fetch_start = 1'b0;
    fetch_base  = pend_q ? pend_base_q : line_base(fetch_line);
    line_ok     = (fetch_line <= LAST_LINE);
    // A fetch deferred from HOST also blocks the host, so it starts on the very next cycle.
    host_wr_ready = alive_q && (state_q == ST_IDLE) && !fetch_req && !pend_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          fetch_start = 1'b1;
          pend_d      = 1'b0;
          state_d     = ST_FETCH;
          if (fetch_req) err_d = 1'b1;
        end else if (fetch_req) begin
          if (line_ok) begin
            fetch_start = 1'b1;
            state_d     = ST_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end else if (host_wr_valid && host_wr_ready) begin
          state_d     = ST_HOST;
          host_addr_d = host_wr_addr;
          host_data_d = host_wr_data;
          host_ok_d   = (host_wr_addr <= FB_LAST);
          if (host_wr_addr > FB_LAST) err_d = 1'b1;
        end
      end
      ST_FETCH: begin
        if (rd_en) begin
          mem_en   = 1'b1;
          mem_addr = rd_addr;
        end
        if (fetch_req) err_d = 1'b1;
        if (done) state_d = ST_IDLE;
      end
      ST_HOST: begin
        if (host_ok_q) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = host_addr_q;
          mem_wdata = host_data_q;
        end
        if (fetch_req) begin
          if (line_ok) begin
            pend_d      = 1'b1;
            pend_base_d = line_base(fetch_line);
          end else begin
            err_d = 1'b1;
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alive_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_base_q <= '0;
      err_q       <= 1'b0;
      host_addr_q <= '0;
      host_data_q <= '0;
      host_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alive_q     <= 1'b1;
      pend_q      <= pend_d;
      pend_base_q <= pend_base_d;
      err_q       <= err_d;
      host_addr_q <= host_addr_d;
      host_data_q <= host_data_d;
      host_ok_q   <= host_ok_d;
    end
  end

  assign fetch_done = done;
  assign fetch_err  = err_q;
  assign lb_wr_en   = lb_bus.lb_wr_en;
  assign lb_wr_idx  = lb_bus.lb_wr_idx;
  assign lb_wr_data = lb_bus.lb_wr_data;

`ifdef VGA_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (host_wr_valid && !host_wr_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter against a time-window reference model and a shadow frame buffer.
// Also checks stall_cnt when VGA_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [8:0]  fetch_line = '0;
  logic        fetch_done, fetch_err;
  logic        host_wr_valid = 1'b0;
  logic        host_wr_ready;
  logic [13:0] host_wr_addr = '0;
  logic [31:0] host_wr_data = '0;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
`ifdef VGA_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  vga_fb_arbiter_if lb_bus ();

  vga_fb_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_req     (fetch_req),
    .fetch_line    (fetch_line),
    .fetch_done    (fetch_done),
    .fetch_err     (fetch_err),
    .host_wr_valid (host_wr_valid),
    .host_wr_ready (host_wr_ready),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .lb_wr_en      (lb_bus.lb_wr_en),
    .lb_wr_idx     (lb_bus.lb_wr_idx),
    .lb_wr_data    (lb_bus.lb_wr_data)
`ifdef VGA_ARB_STATS_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Frame-buffer RAM with one-cycle read latency; the shadow copy holds what it should contain.
  logic [31:0] fb_mem [FB_WORDS];
  logic [31:0] shadow [FB_WORDS];

  always @(posedge clk) begin
    if (mem_en && (mem_addr < 14'(FB_WORDS))) begin
      if (mem_we) fb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata        <= fb_mem[mem_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: fetch occupies cycles f_start..f_start+20, host write occupies h_cyc.
  int   f_start, f_base, h_cyc, h_addr, pend_base, m_stall;
  logic [31:0] h_data;
  bit   h_ok, pend, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    f_start = -100; f_base = 0; h_cyc = -100; h_addr = 0; h_data = '0;
    h_ok = 1'b0; pend = 1'b0; pend_base = 0; m_err = 1'b0; m_stall = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_lb_wr_en"}, 32'(lb_bus.lb_wr_en), 32'd0);
    check({tag, "_lb_data"}, lb_bus.lb_wr_data, 32'd0);
    check({tag, "_done"}, 32'(fetch_done), 32'd0);
    check({tag, "_ready"}, 32'(host_wr_ready), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_req = 1'b0; fetch_line = '0;
    host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    check("rst_err", 32'(fetch_err), 32'd0);
`ifdef VGA_ARB_STATS_EN
    check("rst_stall", 32'(stall_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic fr, input logic [8:0] fl, input logic hv,
                      input logic [13:0] ha, input logic [31:0] hd);
    bit in_f, in_h, idle, e_rdy, e_en, e_we, e_lb;
    int e_addr, k;
    @(posedge clk);
    #1;
    fetch_req = fr; fetch_line = fl;
    host_wr_valid = hv; host_wr_addr = ha; host_wr_data = hd;
    cyc++;
    @(negedge clk);
    in_f  = (f_start >= 0) && (cyc >= f_start) && (cyc <= f_start + 20);
    in_h  = (cyc == h_cyc);
    idle  = !in_f && !in_h;
    e_rdy = idle && !fr && !pend;
    e_en = 1'b0; e_we = 1'b0; e_addr = 0;
    if (in_f && cyc < f_start + 20) begin e_en = 1'b1; e_addr = f_base + cyc - f_start; end
    if (in_h && h_ok) begin e_en = 1'b1; e_we = 1'b1; e_addr = h_addr; end
    e_lb = in_f && (cyc >= f_start + 1);

    check("ready", 32'(host_wr_ready), 32'(e_rdy));
    check("mem_en", 32'(mem_en), 32'(e_en));
    check("mem_we", 32'(mem_we), 32'(e_we));
    if (e_en) check("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_we) check("mem_wdata", mem_wdata, h_data);
    check("lb_wr_en", 32'(lb_bus.lb_wr_en), 32'(e_lb));
    if (e_lb) begin
      k = cyc - f_start - 1;
      check("lb_idx", 32'(lb_bus.lb_wr_idx), 32'(k));
      check("lb_data", lb_bus.lb_wr_data, shadow[f_base + k]);
    end
    check("done", 32'(fetch_done), 32'(in_f && (cyc == f_start + 20)));
    check("err", 32'(fetch_err), 32'(m_err));
`ifdef VGA_ARB_STATS_EN
    check("stall", 32'(stall_cnt), 32'(m_stall));
    if (hv && !e_rdy && m_stall < 65535) m_stall++;
`endif

    if (in_h && h_ok) shadow[h_addr] = h_data;
    if (idle) begin
      if (pend) begin
        f_start = cyc + 1; f_base = pend_base; pend = 1'b0;
        if (fr) m_err = 1'b1;
      end else if (fr) begin
        if (int'(fl) < 480) begin f_start = cyc + 1; f_base = int'(fl) * 20; end
        else m_err = 1'b1;
      end else if (hv) begin
        h_cyc = cyc + 1; h_addr = int'(ha); h_data = hd;
        h_ok = (int'(ha) < 9600);
        if (!h_ok) m_err = 1'b1;
      end
    end else if (in_h) begin
      if (fr) begin
        if (int'(fl) < 480) begin pend = 1'b1; pend_base = int'(fl) * 20; end
        else m_err = 1'b1;
      end
    end else if (fr) begin
      m_err = 1'b1;
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 9'd0, 1'b0, 14'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < int'(FB_WORDS); i++) begin
      fb_mem[i] = $urandom;
      shadow[i] = fb_mem[i];
    end
    model_reset();
    do_reset();

    // Line 5 prefetch: addresses 100..119, line-buffer indices 0..19, done on cycle 21.
    step(1'b1, 9'd5, 1'b0, 14'd0, 32'd0);
    idle_steps(23);

    // Single host write while idle.
    step(1'b0, 9'd0, 1'b1, 14'd42, 32'hDEADBEEF);
    idle_steps(2);

    // Fetch and host in the same cycle; host waits with valid held until after fetch_done.
    step(1'b1, 9'd7, 1'b1, 14'd100, 32'h12345678);
    for (int i = 0; i < 22; i++) step(1'b0, 9'd0, 1'b1, 14'd100, 32'h12345678);
    idle_steps(2);

    // Fetch arriving during a host write is deferred by one cycle; re-read line 5 to see addr 100.
    step(1'b0, 9'd0, 1'b1, 14'd105, 32'hCAFEF00D);
    step(1'b1, 9'd5, 1'b0, 14'd0, 32'd0);
    idle_steps(24);

    // Fetch request during a fetch is ignored and sets the sticky error.
    step(1'b1, 9'd10, 1'b0, 14'd0, 32'd0);
    step(1'b1, 9'd11, 1'b0, 14'd0, 32'd0);
    idle_steps(25);

    // Out-of-range line, then out-of-range host address.
    do_reset();
    step(1'b1, 9'd480, 1'b0, 14'd0, 32'd0);
    idle_steps(3);
    do_reset();
    step(1'b0, 9'd0, 1'b1, 14'd9600, 32'h55AA55AA);
    idle_steps(3);
    step(1'b1, 9'd479, 1'b0, 14'd0, 32'd0);
    idle_steps(23);

    // Reset during cycle 10 of a fetch aborts it at once.
    do_reset();
    step(1'b1, 9'd20, 1'b0, 14'd0, 32'd0);
    idle_steps(9);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(fetch_done), 32'd0);
    end
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 9'd0, 1'b0, 14'd0, 32'd0);
    check("ready_after_abort", 32'(host_wr_ready), 32'd1);

    // Randomized traffic, with periodic resets so the sticky error does not mask everything.
    for (int blk = 0; blk < 8; blk++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        logic        fr, hv;
        logic [8:0]  fl;
        logic [13:0] ha;
        fr = ($urandom_range(0, 15) == 0);
        fl = ($urandom_range(0, 63) == 0) ? 9'(480 + $urandom_range(0, 31))
                                          : 9'($urandom_range(0, 479));
        hv = ($urandom_range(0, 2) != 0);
        ha = ($urandom_range(0, 99) == 0) ? 14'(9600 + $urandom_range(0, 200))
                                          : 14'($urandom_range(0, 9599));
        step(fr, fl, hv, ha, $urandom);
      end
    end
    idle_steps(25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
